rb_stream_buffer: RTL and testbench

RB_STREAM_BUFFER -- requirements
Module: rb_stream_buffer

---
 rtl/rb_pkg.sv | 24 ++
 rtl/rb_mem.sv | 21 ++
 rtl/rb_stream_buffer.sv | 101 ++++++++++
 tb/tb_rb_stream_buffer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rb_pkg.sv
// Shared defaults, operation encoding and width helpers for the ring-buffer stream FIFO.
package rb_pkg;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AE_THRESH = 1;
  localparam bit DEF_OVERWRITE = 1'b0;

  // Per-edge occupancy action; OP_OVWR replaces the oldest entry while full.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_BOTH,
    OP_OVWR
  } rb_op_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/rb_mem.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module rb_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/rb_stream_buffer.sv
// Show-ahead circular stream buffer with level/status flags and optional drop-oldest overwrite.
module rb_stream_buffer
  import rb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = DEF_AE_THRESH,
  parameter bit OVERWRITE = DEF_OVERWRITE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         i_data,
  input  logic                      i_valid,
  output logic                      i_ready,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      ovf,
  input  logic                      ovf_clr
);
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q;
  logic          ovf_q;
  logic          push, pop, ovf_set;
  rb_op_e        op;

  assign full         = (level_q == LW'(DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LW'(AF_THRESH));
  assign almost_empty = (level_q <= LW'(AE_THRESH));
  assign level        = level_q;
  assign ovf          = ovf_q;
  assign o_valid      = !empty;

  // Overwrite mode never back-pressures; only reset blocks a write.
  assign i_ready = OVERWRITE ? !rst : (!full && !rst);
  assign push    = i_valid && i_ready;
  assign pop     = o_valid && o_ready;

  always_comb begin
    op      = OP_IDLE;
    ovf_set = 1'b0;
    unique case ({push, pop})
      2'b10:   op = full ? OP_OVWR : OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
    if (op == OP_OVWR) ovf_set = 1'b1;
    if (!OVERWRITE && full && i_valid) ovf_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          wr_ptr  <= wr_ptr + 1'b1;
          level_q <= level_q + 1'b1;
        end
        OP_POP: begin
          rd_ptr  <= rd_ptr + 1'b1;
          level_q <= level_q - 1'b1;
        end
        OP_BOTH, OP_OVWR: begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        default: ;
      endcase
      // Clear wins over a same-edge set so software always sees its clear land.
      ovf_q <= ovf_clr ? 1'b0 : (ovf_q | ovf_set);
    end
  end

  rb_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (i_data),
    .raddr (rd_ptr),
    .rdata (o_data)
  );
endmodule

// File: tb/tb_rb_stream_buffer.sv
// Scoreboard bench: two buffers (refuse / overwrite) share stimulus, each checked against a queue model.
module tb_rb_stream_buffer;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       o_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  logic [1:0]    i_ready_w, o_valid_w, full_w, empty_w, af_w, ae_w, ovf_w;
  logic [7:0]    o_data_w [2];
  logic [LW-1:0] level_w  [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rb_stream_buffer #(.DATA_W(8), .DEPTH(DEPTH), .OVERWRITE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready_w[0]),
    .o_data(o_data_w[0]), .o_valid(o_valid_w[0]), .o_ready(o_ready), .level(level_w[0]),
    .full(full_w[0]), .empty(empty_w[0]), .almost_full(af_w[0]), .almost_empty(ae_w[0]),
    .ovf(ovf_w[0]), .ovf_clr(ovf_clr));

  rb_stream_buffer #(.DATA_W(8), .DEPTH(DEPTH), .OVERWRITE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready_w[1]),
    .o_data(o_data_w[1]), .o_valid(o_valid_w[1]), .o_ready(o_ready), .level(level_w[1]),
    .full(full_w[1]), .empty(empty_w[1]), .almost_full(af_w[1]), .almost_empty(ae_w[1]),
    .ovf(ovf_w[1]), .ovf_clr(ovf_clr));

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] t=%0t got=0x%0h expected=0x%0h", name, k, $time, act, exp);
    end
  endtask

  // Reference model: expected contents as a queue, plus sticky overflow flag.
  logic [7:0] mq [2][$];
  bit         ovf_m [2];
  bit         armed = 1'b0;

  // Inputs are stable from posedge+1 to the next posedge; at negedge check the
  // current state, then advance the model to what the coming edge should do.
  always @(negedge clk) begin
    int  sz;
    bit  ow, pop_m, full_m, set_m;
    for (int k = 0; k < 2; k++) begin
      sz = mq[k].size();
      ow = (k == 1);
      if (armed) begin
        chk("i_ready", k, 32'(i_ready_w[k]), 32'(!rst && (ow || sz < DEPTH)));
        chk("level", k, 32'(level_w[k]), 32'(sz));
        chk("o_valid", k, 32'(o_valid_w[k]), 32'(sz > 0));
        chk("full", k, 32'(full_w[k]), 32'(sz == DEPTH));
        chk("empty", k, 32'(empty_w[k]), 32'(sz == 0));
        chk("almost_full", k, 32'(af_w[k]), 32'(sz >= DEPTH - 2));
        chk("almost_empty", k, 32'(ae_w[k]), 32'(sz <= 1));
        chk("ovf", k, 32'(ovf_w[k]), 32'(ovf_m[k]));
      end
      if (rst) begin
        mq[k].delete();
        ovf_m[k] = 1'b0;
      end else begin
        full_m = (sz == DEPTH);
        pop_m  = (sz > 0) && o_ready;
        set_m  = 1'b0;
        if (pop_m) begin
          if (armed) chk("pop_data", k, 32'(o_data_w[k]), 32'(mq[k][0]));
          void'(mq[k].pop_front());
        end
        if (i_valid) begin
          if (!full_m) mq[k].push_back(i_data);
          else if (ow) begin
            if (!pop_m) begin
              void'(mq[k].pop_front());
              set_m = 1'b1;
            end
            mq[k].push_back(i_data);
          end else set_m = 1'b1;
        end
        ovf_m[k] = ovf_clr ? 1'b0 : (ovf_m[k] | set_m);
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic step(input bit v, input logic [7:0] d, input bit r, input bit clr);
    i_valid = v;
    i_data  = d;
    o_ready = r;
    ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic drain();
    repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    do_reset(2);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Two pushes, no pops: show-ahead of the first entry.
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Overfill by one, then drain in order.
    do_reset(1);
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Overfill by four: overwrite buffer keeps 0x04..0x13.
    do_reset(1);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    drain();

    // Fill, then 40 cycles of simultaneous push/pop across pointer wrap.
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
    drain();

    // Reset mid-operation with both handshakes asserted, then reuse.
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to overflow, clear in the same cycle as another refused write,
    // then drain one at a time across the almost_full threshold.
    do_reset(1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
    drain();

    // Randomized traffic with phases biased toward filling and draining.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      int pv, pr;
      pv = ((i / 200) % 2 == 0) ? 75 : 35;
      pr = ((i / 200) % 2 == 0) ? 30 : 70;
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < pr,
           $urandom_range(0, 19) == 0);
    end
    rst = 1'b0;
    drain();
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
